char_pwm_decode: RTL and testbench

Receive-side decoder for the phase-encoded 16-segment character link driven by `char_pwm_gen`. It samples the 16 `digit` lines against the transmitted reference clock `clk_out`. A line toggling in phase with the reference carries a 1; a line toggling in antiphase carries a 0. It recovers the 2-bit character code (A/J/N/X), filters it over consecutive periods, and reports link errors and loss. It sits on the receiving board or ASIC pin side, clocked by a local system clock that is much faster than the link reference.

---
 rtl/char_pwm_decode_pkg.sv | 60 ++++++
 rtl/char_pwm_decode_if.sv | 31 +++
 rtl/char_pwm_decode_sync_2ff.sv | 33 +++
 rtl/char_pwm_decode.sv | 203 ++++++++++++++++++++
 tb/tb_char_pwm_decode.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/char_pwm_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : char_pwm_pkg
// Description : Shared constants and types for the phase-encoded 16-segment
//               character link (patterns, character codes, error codes,
//               decoder FSM states).
// Revision    : 1.0 - initial release
// ============================================================================
package char_pwm_pkg;

  // Segment patterns as seen in the high half of the reference (1 = in phase)
  localparam logic [15:0] c_PAT_A = 16'h9F8F;
  localparam logic [15:0] c_PAT_J = 16'h6998;
  localparam logic [15:0] c_PAT_N = 16'h9DA9;
  localparam logic [15:0] c_PAT_X = 16'h9679;

  typedef enum logic [1:0] {
    CHAR_A = 2'b00,
    CHAR_J = 2'b01,
    CHAR_N = 2'b10,
    CHAR_X = 2'b11
  } char_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_PHASE   = 2'b01,
    ERR_UNKNOWN = 2'b10,
    ERR_GLITCH  = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE_HI = 3'd1,
    ST_WAIT_FALL = 3'd2,
    ST_SETTLE_LO = 3'd3,
    ST_EVAL      = 3'd4
  } state_e;

  typedef struct packed {
    logic  hit;
    char_e code;
  } match_t;

  // Look a captured high-phase word up in the pattern table
  function automatic match_t match_pattern(input logic [15:0] word);
    match_t m;
    m.hit  = 1'b1;
    m.code = CHAR_A;
    case (word)
      c_PAT_A: m.code = CHAR_A;
      c_PAT_J: m.code = CHAR_J;
      c_PAT_N: m.code = CHAR_N;
      c_PAT_X: m.code = CHAR_X;
      default: m.hit  = 1'b0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/char_pwm_decode_if.sv
`default_nettype none
// ============================================================================
// Module      : char_pwm_decode_if
// Description : Link pins and decoded-status bundle of the character decoder.
//               master = link/monitor side, slave = decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface char_pwm_decode_if;
  import char_pwm_pkg::*;

  logic        ref_in;
  logic [15:0] digit_in;
  char_e       char_code;
  logic        char_valid;
  logic        char_strobe;
  logic        err_strobe;
  err_e        err_code;
  logic        link_lost;

  modport master (
    output ref_in, digit_in,
    input  char_code, char_valid, char_strobe, err_strobe, err_code, link_lost
  );

  modport slave (
    input  ref_in, digit_in,
    output char_code, char_valid, char_strobe, err_strobe, err_code, link_lost
  );

endinterface
`default_nettype wire

// File: rtl/char_pwm_decode_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer bank for asynchronous inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [WIDTH-1:0] i_d,
  output logic      [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops give metastability a full cycle to resolve
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/char_pwm_decode.sv
`default_nettype none
// ============================================================================
// Module      : char_pwm_decode
// Description : Receive-side decoder for the phase-encoded character link.
//               Samples the segment lines after each reference edge, checks
//               the two halves are complementary, looks up the character,
//               filters it over consecutive periods and reports errors/loss.
// Revision    : 1.0 - initial release
// ============================================================================
module char_pwm_decode
  import char_pwm_pkg::*;
#(
  parameter int          SETTLE      = 4,
  parameter int          MATCH_COUNT = 2,
  parameter logic [31:0] TIMEOUT     = 32'd1048576
) (
  input wire logic          clk,
  input wire logic          rst,
  char_pwm_decode_if.slave  bus
);

  localparam logic [31:0] c_SETTLE_LAST = 32'(SETTLE - 1);
  localparam logic [3:0]  c_MATCH       = 4'(MATCH_COUNT);

  logic [16:0] w_sync;
  logic        w_ref_s;
  logic [15:0] w_dig_s;
  logic        r_ref_d;
  logic        w_rise, w_fall, w_edge;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] r_wd;
  logic [15:0] r_hi, r_lo;
  logic        w_cnt_clr, w_cnt_inc, w_cap_hi, w_cap_lo, w_glitch, w_eval;
  logic        w_timeout;

  char_e       r_cand;
  logic [3:0]  r_streak;
  char_e       r_code;
  logic        r_valid, r_char_strobe, r_err_strobe, r_link_lost;
  err_e        r_err_code;

  match_t      w_match;
  logic        w_phase_ok, w_good, w_err_eval, w_confirm;
  logic [3:0]  w_streak_new;
  err_e        w_err_kind;

  sync_2ff #(.WIDTH(17)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({bus.ref_in, bus.digit_in}),
    .o_q (w_sync)
  );

  assign w_ref_s = w_sync[16];
  assign w_dig_s = w_sync[15:0];
  assign w_rise  = w_ref_s & ~r_ref_d;
  assign w_fall  = ~w_ref_s & r_ref_d;
  assign w_edge  = w_rise | w_fall;

  // Fires once per silent stretch: the watchdog saturates past TIMEOUT
  assign w_timeout = ~w_edge & (r_wd == TIMEOUT - 32'd1);

  // Delayed reference for edge detection and the saturating link watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_d <= 1'b0;
      r_wd    <= '0;
    end else begin
      r_ref_d <= w_ref_s;
      if (w_edge)
        r_wd <= '0;
      else if (r_wd != 32'hFFFF_FFFF)
        r_wd <= r_wd + 32'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; an opposite edge during settling beats terminal count
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cap_hi    = 1'b0;
    w_cap_lo    = 1'b0;
    w_glitch    = 1'b0;
    w_eval      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_SETTLE_HI;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_SETTLE_HI: begin
        if (w_fall) begin
          w_glitch    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_SETTLE_LAST) begin
          w_cap_hi    = 1'b1;
          w_state_nxt = ST_WAIT_FALL;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      ST_WAIT_FALL: begin
        if (w_fall) begin
          w_state_nxt = ST_SETTLE_LO;
          w_cnt_clr   = 1'b1;
        end
      end
      ST_SETTLE_LO: begin
        if (w_rise) begin
          w_glitch    = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == c_SETTLE_LAST) begin
          w_cap_lo    = 1'b1;
          w_state_nxt = ST_EVAL;
        end else begin
          w_cnt_inc   = 1'b1;
        end
      end
      ST_EVAL: begin
        w_eval      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_timeout) w_state_nxt = ST_IDLE;
  end

  // Period evaluation; a coincident timeout discards the result
  always_comb begin
    w_match      = match_pattern(r_hi);
    w_phase_ok   = (r_lo == ~r_hi);
    w_streak_new = 4'd1;
    if (w_match.code == r_cand)
      w_streak_new = (r_streak == c_MATCH) ? r_streak : r_streak + 4'd1;
    w_good       = w_eval & ~w_timeout & w_phase_ok & w_match.hit;
    w_err_eval   = w_eval & ~w_timeout & ~(w_phase_ok & w_match.hit);
    w_confirm    = w_good & (w_streak_new == c_MATCH) &
                   ((w_match.code != r_code) | ~r_valid);
    w_err_kind   = ERR_GLITCH;
    if (w_err_eval) w_err_kind = w_phase_ok ? ERR_UNKNOWN : ERR_PHASE;
  end

  // Settle counter, captures, match filter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_cand        <= CHAR_A;
      r_streak      <= '0;
      r_code        <= CHAR_A;
      r_valid       <= 1'b0;
      r_char_strobe <= 1'b0;
      r_err_strobe  <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_link_lost   <= 1'b1;
    end else begin
      r_char_strobe <= 1'b0;
      r_err_strobe  <= 1'b0;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 32'd1;
      if (w_cap_hi) r_hi <= w_dig_s;
      if (w_cap_lo) r_lo <= w_dig_s;
      if (w_timeout) begin
        r_link_lost <= 1'b1;
        r_valid     <= 1'b0;
        r_streak    <= '0;
      end else if (w_glitch || w_err_eval) begin
        r_err_strobe <= 1'b1;
        r_err_code   <= w_err_kind;
        r_streak     <= '0;
      end else if (w_good) begin
        r_link_lost <= 1'b0;
        r_cand      <= w_match.code;
        r_streak    <= w_streak_new;
        if (w_confirm) begin
          r_code        <= w_match.code;
          r_valid       <= 1'b1;
          r_char_strobe <= 1'b1;
        end
      end
    end
  end

  assign bus.char_code   = r_code;
  assign bus.char_valid  = r_valid;
  assign bus.char_strobe = r_char_strobe;
  assign bus.err_strobe  = r_err_strobe;
  assign bus.err_code    = r_err_code;
  assign bus.link_lost   = r_link_lost;

endmodule
`default_nettype wire

// File: tb/tb_char_pwm_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_char_pwm_decode
// Description : Self-checking bench for char_pwm_decode. Table of reference
//               periods with expected strobes (scoreboard queue) and levels,
//               plus hand-written timeout and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_char_pwm_decode;
  import char_pwm_pkg::*;

  localparam int          SETTLE = 4;
  localparam int          MC     = 2;
  localparam logic [31:0] TO     = 32'd300;

  localparam logic [1:0] EV_NONE = 2'd0;
  localparam logic [1:0] EV_CHAR = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  typedef struct {
    logic [1:0] kind;
    logic [1:0] code;
  } ev_t;

  typedef struct {
    logic [15:0] word;
    logic [15:0] flip;
    int          half;
    logic [1:0]  kind;
    logic [1:0]  ecode;
    logic [1:0]  code;
    logic        valid;
    logic        lost;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  char_pwm_decode_if bus();

  char_pwm_decode #(
    .SETTLE      (SETTLE),
    .MATCH_COUNT (MC),
    .TIMEOUT     (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ev_t  q[$];
  ev_t  r_ev;
  vec_t vecs[16];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] w, input logic [15:0] f, input int h,
                              input logic [1:0] k, input logic [1:0] ec,
                              input logic [1:0] c, input logic v, input logic l);
    vec_t r;
    r.word = w; r.flip = f; r.half = h; r.kind = k; r.ecode = ec;
    r.code = c; r.valid = v; r.lost = l;
    return r;
  endfunction

  // One reference period: in-phase word while high, its complement (xor flip) while low
  task automatic period(input logic [15:0] w, input logic [15:0] flip, input int half);
    @(negedge clk);
    bus.ref_in   = 1'b1;
    bus.digit_in = w;
    repeat (half) @(negedge clk);
    bus.ref_in   = 1'b0;
    bus.digit_in = ~w ^ flip;
    repeat (half + 12) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] kind, input logic [1:0] code);
    ev_t e;
    e.kind = kind;
    e.code = code;
    if (kind != EV_NONE) q.push_back(e);
  endtask

  task automatic levels(input string tag, input logic [1:0] code, input logic valid, input logic lost);
    check({tag, " pending_events"}, q.size(), 0);
    q.delete();
    check({tag, " char_code"}, bus.char_code, code);
    check({tag, " char_valid"}, bus.char_valid, valid);
    check({tag, " link_lost"}, bus.link_lost, lost);
  endtask

  // Scoreboard: every strobe must match the oldest expected event
  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.char_strobe || bus.err_strobe)) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: got char_strobe=%0b err_strobe=%0b required none",
                 bus.char_strobe, bus.err_strobe);
      end else begin
        r_ev = q.pop_front();
        check("strobe_kind", {30'd0, bus.err_strobe, bus.char_strobe}, {30'd0, r_ev.kind});
        if (r_ev.kind == EV_CHAR) check("char_code@strobe", bus.char_code, r_ev.code);
        else                      check("err_code@strobe", bus.err_code, r_ev.code);
      end
    end
  end

  initial begin
    bus.ref_in   = 1'b0;
    bus.digit_in = 16'h0000;

    //             word     flip     half kind     ecode  code   v     l
    vecs[0]  = mk(c_PAT_N, 16'h0000, 32, EV_NONE, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[1]  = mk(c_PAT_N, 16'h0000, 32, EV_CHAR, 2'b10, 2'b10, 1'b1, 1'b0);
    vecs[2]  = mk(c_PAT_A, 16'h0000, 32, EV_NONE, 2'b00, 2'b10, 1'b1, 1'b0);
    vecs[3]  = mk(c_PAT_A, 16'h0000, 32, EV_CHAR, 2'b00, 2'b00, 1'b1, 1'b0);
    vecs[4]  = mk(c_PAT_X, 16'h0000, 32, EV_NONE, 2'b00, 2'b00, 1'b1, 1'b0);
    vecs[5]  = mk(c_PAT_A, 16'h0000, 32, EV_NONE, 2'b00, 2'b00, 1'b1, 1'b0);
    vecs[6]  = mk(c_PAT_A, 16'h0000, 32, EV_NONE, 2'b00, 2'b00, 1'b1, 1'b0);
    vecs[7]  = mk(c_PAT_X, 16'h0000, 32, EV_NONE, 2'b00, 2'b00, 1'b1, 1'b0);
    vecs[8]  = mk(c_PAT_X, 16'h0000, 32, EV_CHAR, 2'b11, 2'b11, 1'b1, 1'b0);
    vecs[9]  = mk(16'h1234, 16'h0000, 32, EV_ERR, 2'b10, 2'b11, 1'b1, 1'b0);
    vecs[10] = mk(c_PAT_N, 16'h0020, 32, EV_ERR,  2'b01, 2'b11, 1'b1, 1'b0);
    vecs[11] = mk(c_PAT_N, 16'h0000, 3,  EV_ERR,  2'b11, 2'b11, 1'b1, 1'b0);
    vecs[12] = mk(c_PAT_N, 16'h0000, 32, EV_NONE, 2'b00, 2'b11, 1'b1, 1'b0);
    vecs[13] = mk(16'h1234, 16'h0000, 32, EV_ERR, 2'b10, 2'b11, 1'b1, 1'b0);
    vecs[14] = mk(c_PAT_N, 16'h0000, 32, EV_NONE, 2'b00, 2'b11, 1'b1, 1'b0);
    vecs[15] = mk(c_PAT_N, 16'h0000, 32, EV_CHAR, 2'b10, 2'b10, 1'b1, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst char_code", bus.char_code, 2'b00);
    check("rst char_valid", bus.char_valid, 1'b0);
    check("rst link_lost", bus.link_lost, 1'b1);
    check("rst char_strobe", bus.char_strobe, 1'b0);
    check("rst err_strobe", bus.err_strobe, 1'b0);
    check("rst err_code", bus.err_code, 2'b00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Table-driven periods
    for (int i = 0; i < 16; i++) begin
      push(vecs[i].kind, vecs[i].ecode);
      period(vecs[i].word, vecs[i].flip, vecs[i].half);
      levels($sformatf("v%0d", i), vecs[i].code, vecs[i].valid, vecs[i].lost);
    end

    // Reference stops beyond the watchdog limit
    repeat (int'(TO) + 20) @(negedge clk);
    levels("timeout", 2'b10, 1'b0, 1'b1);

    // Restart with J: first good period clears loss, second confirms
    period(c_PAT_J, 16'h0000, 32);
    levels("restart1", 2'b10, 1'b0, 1'b0);
    push(EV_CHAR, 2'b01);
    period(c_PAT_J, 16'h0000, 32);
    levels("restart2", 2'b01, 1'b1, 1'b0);

    // Reset in the middle of a high phase takes effect without a clock edge
    @(negedge clk);
    bus.ref_in   = 1'b1;
    bus.digit_in = c_PAT_N;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst char_code", bus.char_code, 2'b00);
    check("midrst char_valid", bus.char_valid, 1'b0);
    check("midrst link_lost", bus.link_lost, 1'b1);
    check("midrst err_code", bus.err_code, 2'b00);
    bus.ref_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    period(c_PAT_N, 16'h0000, 32);
    levels("postrst1", 2'b00, 1'b0, 1'b0);
    push(EV_CHAR, 2'b10);
    period(c_PAT_N, 16'h0000, 32);
    levels("postrst2", 2'b10, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
